pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: single outstanding fetch, one-deep instruction hold
// register, and branch redirect with a flush pulse and a saturating redirect count.
//
// state | meaning
// REQ   | fetch request driven at PC, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented to decode until consumed
// DROP  | stale response outstanding after a redirect, discard it
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic        ExValid,
  input  logic [31:0] BrTarget,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  output logic        InstValid,
  output logic        Flush,
  output logic [15:0] FlushCnt
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, fetch_pc;
  logic        redirect, gnt_ok;

  assign redirect = ExValid & NextPCSrc;
  // IMemReq is low in the first cycle out of reset, so a grant only counts when requested
  assign gnt_ok   = IMemReq & IMemGnt;
  assign IMemAddr = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      REQ: begin
        if (redirect)    state_nxt = gnt_ok ? DROP : REQ;
        else if (gnt_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (IMemRValid)    state_nxt = redirect ? REQ : HOLD;
        else if (redirect) state_nxt = DROP;
      end
      HOLD: begin
        if (redirect || !Stall) state_nxt = REQ;
      end
      // a redirect never abandons the outstanding response; it still has to be drained
      DROP: begin
        if (IMemRValid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      pc        <= RESET_PC;
      fetch_pc  <= RESET_PC;
      Inst      <= '0;
      InstPC    <= '0;
      InstValid <= 1'b0;
      Flush     <= 1'b0;
      FlushCnt  <= '0;
      IMemReq   <= 1'b0;
    end else begin
      state   <= state_nxt;
      IMemReq <= (state_nxt == REQ);
      Flush   <= redirect;
      if (redirect) begin
        pc        <= {BrTarget[31:2], 2'b00};
        InstValid <= 1'b0;
        if (FlushCnt != 16'hFFFF) FlushCnt <= FlushCnt + 16'd1;
      end else begin
        case (state)
          REQ: begin
            if (gnt_ok) fetch_pc <= pc;
          end
          WAIT: begin
            if (IMemRValid) begin
              Inst      <= IMemRData;
              InstPC    <= fetch_pc;
              InstValid <= 1'b1;
              pc        <= pc + 32'd4;
            end
          end
          HOLD: begin
            if (!Stall) InstValid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle vector table plus saturation and
// asynchronous reset sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        NextPCSrc, ExValid, Stall, IMemGnt, IMemRValid;
  logic [31:0] BrTarget, IMemRData;
  logic        IMemReq, InstValid, Flush;
  logic [31:0] IMemAddr, Inst, InstPC;
  logic [15:0] FlushCnt;

  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(NextPCSrc), .ExValid(ExValid),
    .BrTarget(BrTarget), .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
    .Inst(Inst), .InstPC(InstPC), .InstValid(InstValid), .Flush(Flush),
    .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv, stall, exv, npc;
    logic [31:0] rdata, tgt;
    logic        e_req, e_iv, e_flush;
    logic [31:0] e_addr, e_inst, e_ipc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic iv, input logic [31:0] inst, input logic [31:0] ipc,
                           input logic fl, input logic [15:0] cnt);
    chk({tag, "_req"},   {31'd0, IMemReq},   {31'd0, req});
    chk({tag, "_addr"},  IMemAddr,           addr);
    chk({tag, "_iv"},    {31'd0, InstValid}, {31'd0, iv});
    chk({tag, "_inst"},  Inst,               inst);
    chk({tag, "_ipc"},   InstPC,             ipc);
    chk({tag, "_flush"}, {31'd0, Flush},     {31'd0, fl});
    chk({tag, "_cnt"},   {16'd0, FlushCnt},  {16'd0, cnt});
  endtask

  task automatic add(input logic gnt, rv, input logic [31:0] rdata, input logic stall, exv, npc,
                     input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                     input logic iv, input logic [31:0] inst, ipc, input logic fl,
                     input logic [15:0] cnt);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = stall; v.exv = exv; v.npc = npc;
    v.tgt = tgt; v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_inst = inst;
    v.e_ipc = ipc; v.e_flush = fl; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic gnt, rv, input logic [31:0] rdata, input logic stall, exv, npc,
                       input logic [31:0] tgt);
    IMemGnt = gnt; IMemRValid = rv; IMemRData = rdata; Stall = stall;
    ExValid = exv; NextPCSrc = npc; BrTarget = tgt;
  endtask

  initial begin
    // gnt rv rdata stall exv npc tgt | req addr iv inst ipc flush cnt  (state after edge)
    add(0,0,0,0,0,0,0,            1,32'h0,0,32'h0,32'h0,0,0);            // 0 REQ
    add(1,0,0,0,0,0,0,            0,32'h0,0,32'h0,32'h0,0,0);            // 1 WAIT
    add(0,0,0,0,0,0,0,            0,32'h0,0,32'h0,32'h0,0,0);            // 2 WAIT
    add(0,1,32'h13,0,0,0,0,       0,32'h4,1,32'h13,32'h0,0,0);           // 3 HOLD
    add(0,0,0,1,0,0,0,            0,32'h4,1,32'h13,32'h0,0,0);           // 4 stall
    add(0,0,0,1,0,0,0,            0,32'h4,1,32'h13,32'h0,0,0);           // 5 stall
    add(0,0,0,1,0,0,0,            0,32'h4,1,32'h13,32'h0,0,0);           // 6 stall
    add(0,0,0,0,0,0,0,            1,32'h4,0,32'h13,32'h0,0,0);           // 7 REQ
    add(0,1,32'hDEAD,0,0,0,0,     1,32'h4,0,32'h13,32'h0,0,0);           // 8 stray rvalid
    add(1,0,0,0,0,0,0,            0,32'h4,0,32'h13,32'h0,0,0);           // 9 WAIT
    add(0,0,0,0,1,1,32'h102,      0,32'h100,0,32'h13,32'h0,1,1);         // 10 DROP
    add(0,0,0,0,0,0,0,            0,32'h100,0,32'h13,32'h0,0,1);         // 11 DROP
    add(0,1,32'hBAD,0,0,0,0,      1,32'h100,0,32'h13,32'h0,0,1);         // 12 discard
    add(1,0,0,0,0,1,32'h555,      0,32'h100,0,32'h13,32'h0,0,1);         // 13 exv=0
    add(0,1,32'h22,0,0,0,0,       0,32'h104,1,32'h22,32'h100,0,1);       // 14 HOLD
    add(0,0,0,1,1,1,32'h203,      1,32'h200,0,32'h22,32'h100,1,2);       // 15 redirect over stall
    add(1,0,0,0,1,1,32'h300,      0,32'h300,0,32'h22,32'h100,1,3);       // 16 REQ+gnt -> DROP
    add(0,1,32'h77,0,0,0,0,       1,32'h300,0,32'h22,32'h100,0,3);       // 17 discard
    add(0,0,0,0,1,1,32'h404,      1,32'h404,0,32'h22,32'h100,1,4);       // 18 REQ no gnt
    add(1,0,0,0,0,0,0,            0,32'h404,0,32'h22,32'h100,0,4);       // 19 WAIT
    add(0,1,32'h55,0,1,1,32'h500, 1,32'h500,0,32'h22,32'h100,1,5);       // 20 WAIT+rv redirect
    add(0,0,0,0,0,0,0,            1,32'h500,0,32'h22,32'h100,0,5);       // 21 REQ
    add(0,0,0,0,1,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,32'h22,32'h100,1,6); // 22
    add(1,0,0,0,0,0,0,            0,32'hFFFF_FFFC,0,32'h22,32'h100,0,6); // 23
    add(0,1,32'h99,0,0,0,0,       0,32'h0,1,32'h99,32'hFFFF_FFFC,0,6);   // 24 wrap
    add(0,0,0,0,0,0,0,            1,32'h0,0,32'h99,32'hFFFF_FFFC,0,6);   // 25

    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 check_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("first_cycle_req", {31'd0, IMemReq}, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].stall, vecs[i].exv,
            vecs[i].npc, vecs[i].tgt);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_flush, vecs[i].e_cnt);
    end

    // 70000 back-to-back redirects; count started at 6
    drive(0,0,0,0,1,1,32'h1000);
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk); #1;
      if (n == 65528) chk("cnt_before_sat", {16'd0, FlushCnt}, 32'h0000_FFFE);
    end
    chk("cnt_sat", {16'd0, FlushCnt}, 32'h0000_FFFF);
    chk("flush_held", {31'd0, Flush}, 32'd1);
    drive(0,0,0,0,0,0,0);
    @(posedge clk); #1;
    check_all("after_sat", 1, 32'h1000, 0, 32'h99, 32'hFFFF_FFFC, 0, 16'hFFFF);

    // reset asserted mid-WAIT takes effect without a clock edge
    drive(1,0,0,0,0,0,0);
    @(posedge clk); #1;
    chk("wait_req", {31'd0, IMemReq}, 32'd0);
    drive(0,0,0,0,0,0,0);
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_req0", {31'd0, IMemReq}, 32'd0);
    @(posedge clk); #1;
    check_all("rel_req1", 1, 32'h0, 0, 32'h0, 32'h0, 0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
